// File: rtl/feedback_pkg.sv
// rtl/feedback_pkg.sv - shared widths and delay clamping for the feedback blocks
package feedback_pkg;

   // Reference geometry used by feedback blocks built at the default depth
   localparam int FB_DEPTH = 16;
   localparam int PTR_W    = $clog2(FB_DEPTH);
   localparam int DLY_W    = PTR_W + 1;

   // Legal delays are 1..depth: zero becomes one, anything larger becomes depth
   function automatic logic [31:0] clamp_delay(input logic [31:0] req,
                                               input logic [31:0] depth);
      logic [31:0] res;
      if (req == 32'd0)
         res = 32'd1;
      else if (req > depth)
         res = depth;
      else
         res = req;
      return res;
   endfunction

endpackage

// File: rtl/delay_ring.sv
// rtl/delay_ring.sv - circular sample store with read-before-write
module delay_ring #(
   parameter int W     = 4,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Write on the edge; the combinational read still sees the pre-edge entry
   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feedback_delay_line.sv
// rtl/feedback_delay_line.sv - multi-channel programmable-depth feedback delay line
module feedback_delay_line
   import feedback_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int WIDTH        = 1,
   parameter int DEPTH        = 16,
   parameter int DELAY_RESET  = 4,
   parameter bit INVERT_RESET = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      cfg_we,
   input  logic [$clog2(DEPTH):0]    cfg_delay,
   input  logic                      cfg_invert,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      primed,
   output logic [$clog2(DEPTH):0]    delay_cur
);

   // Widths follow this instance's DEPTH rather than the package default
   localparam int DW  = CHANNELS * WIDTH;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_idx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] d;
   logic          inv;
   logic [DW-1:0] rd_data;

   // d == DEPTH has zero low bits, so the read lands on the slot being overwritten
   assign rd_idx    = wr_ptr - d[PW-1:0];
   assign primed    = (cnt == d);
   assign delay_cur = d;

   delay_ring #(
      .W     (DW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ring (
      .clk     (clk),
      .we      (in_valid),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_idx),
      .rd_data (rd_data)
   );

   // Pointer, fill count, delay setting and registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         cnt       <= '0;
         d         <= CW'(DELAY_RESET);
         inv       <= INVERT_RESET;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         if (cfg_we) begin
            // Flush: a coincident sample still gets stored and starts the new fill
            d   <= CW'(clamp_delay(32'(cfg_delay), DEPTH_U));
            inv <= cfg_invert;
            cnt <= in_valid ? CW'(1) : CW'(0);
            if (in_valid)
               wr_ptr <= wr_ptr + 1'b1;
         end else if (in_valid) begin
            if (primed) begin
               out_data  <= rd_data ^ {DW{inv}};
               out_valid <= 1'b1;
            end
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt < d)
               cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_feedback_delay_line.sv
// tb/tb_feedback_delay_line.sv - scoreboard bench for feedback_delay_line
module tb_feedback_delay_line;

   localparam int CH = 4;
   localparam int WD = 4;
   localparam int DW = CH * WD;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          cfg_we = 1'b0;
   logic [4:0]    cfg_delay = '0;
   logic          cfg_invert = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          primed;
   logic [4:0]    delay_cur;

   int checks = 0;
   int passed = 0;
   logic [DW-1:0] exp_q[$];
   logic          last_iv = 1'b0;

   feedback_delay_line #(
      .CHANNELS     (CH),
      .WIDTH        (WD),
      .DEPTH        (16),
      .DELAY_RESET  (4),
      .INVERT_RESET (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .cfg_we     (cfg_we),
      .cfg_delay  (cfg_delay),
      .cfg_invert (cfg_invert),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .primed     (primed),
      .delay_cur  (delay_cur)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(posedge clk) last_iv <= in_valid;

   // Monitor: every output pulse must match the oldest expected sample
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("out_valid_has_strobe", {31'd0, last_iv}, 32'd1);
         if (exp_q.size() == 0)
            chk("unexpected_output", {16'd0, out_data}, 32'hFFFF_FFFF);
         else
            chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
   end

   task automatic strobe(input logic [DW-1:0] data, input bit exp_out, input logic [DW-1:0] exp_data);
      if (exp_out)
         exp_q.push_back(exp_data);
      in_valid = 1'b1;
      in_data  = data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cfg(input logic [4:0] dly, input bit inv, input bit with_sample, input logic [DW-1:0] data);
      cfg_we     = 1'b1;
      cfg_delay  = dly;
      cfg_invert = inv;
      in_valid   = with_sample;
      in_data    = data;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_defaults_scenario();
      chk("rst_delay_cur", {27'd0, delay_cur}, 32'd4);
      chk("rst_primed", {31'd0, primed}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         strobe(DW'(i), i > 4, DW'(i - 4));
         if (i == 3) chk("primed_before_fill", {31'd0, primed}, 32'd0);
         if (i == 4) chk("primed_after_fill", {31'd0, primed}, 32'd1);
      end
      idle(2);
   endtask

   initial begin
      // Reset defaults
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      reset_defaults_scenario();

      // Full depth with pointer wrap
      cfg(5'd16, 1'b0, 1'b0, '0);
      chk("delay_cur_16", {27'd0, delay_cur}, 32'd16);
      for (int i = 0; i < 40; i++)
         strobe(DW'(i), i >= 16, DW'(i - 16));
      idle(2);

      // Clamping and inversion
      cfg(5'd0, 1'b0, 1'b0, '0);
      chk("clamp_zero", {27'd0, delay_cur}, 32'd1);
      strobe(16'h0011, 1'b0, '0);
      strobe(16'h0022, 1'b1, 16'h0011);
      strobe(16'h0033, 1'b1, 16'h0022);
      idle(2);
      cfg(5'd31, 1'b0, 1'b0, '0);
      chk("clamp_high", {27'd0, delay_cur}, 32'd16);
      cfg(5'd1, 1'b1, 1'b0, '0);
      strobe(16'hAAAA, 1'b0, '0);
      strobe(16'h1234, 1'b1, 16'h5555);
      strobe(16'h0000, 1'b1, 16'hEDCB);
      idle(2);

      // Reconfigure mid-stream with a coincident sample
      cfg(5'd4, 1'b0, 1'b0, '0);
      for (int i = 0; i < 10; i++)
         strobe(DW'(16'h0100 + i), i >= 4, DW'(16'h0100 + i - 4));
      cfg(5'd2, 1'b0, 1'b1, 16'h0A0A);
      chk("reconfig_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reconfig_primed", {31'd0, primed}, 32'd0);
      chk("reconfig_delay", {27'd0, delay_cur}, 32'd2);
      strobe(16'h0B0B, 1'b0, '0);
      strobe(16'h0C0C, 1'b1, 16'h0A0A);
      strobe(16'h0D0D, 1'b1, 16'h0B0B);
      idle(2);

      // Gapped strobes at d=3
      cfg(5'd3, 1'b0, 1'b0, '0);
      for (int i = 0; i < 20; i++) begin
         idle($urandom_range(0, 3));
         strobe(DW'(16'h0200 + i), i >= 3, DW'(16'h0200 + i - 3));
      end
      idle(2);
      chk("primed_before_async_rst", {31'd0, primed}, 32'd1);

      // Asynchronous reset between edges
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_out_data", {16'd0, out_data}, 32'd0);
      chk("async_primed", {31'd0, primed}, 32'd0);
      chk("async_delay_cur", {27'd0, delay_cur}, 32'd4);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      reset_defaults_scenario();

      idle(3);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
